// File: rtl/alu_mul_ctrl_pkg.sv
// alu_mul_ctrl_pkg: ALU op codes, carry flag index and multiplier state encoding
package alu_mul_ctrl_pkg;
  localparam logic [3:0] ALU_TRA = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_ROR = 4'h7;
  localparam int CF = 0;
  typedef enum logic [2:0] {
    MUL_IDLE = 3'd0,
    MUL_ADD  = 3'd1,
    MUL_RORH = 3'd2,
    MUL_RORL = 3'd3,
    MUL_FIN  = 3'd4
  } mul_state_t;
endpackage

// File: rtl/alu_mul_ctrl_if.sv
// alu_mul_ctrl_if: multiply request/result handshake (start,a_in,b_in,busy,done,p) plus ALU drive/return bus
interface alu_mul_ctrl_if;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] p;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_op;
  logic [7:0]  alu_st_in;
  logic [7:0]  alu_r;
  logic [7:0]  alu_st_out;
  modport master (
    output start, a_in, b_in, alu_r, alu_st_out,
    input  busy, done, p, alu_a, alu_b, alu_op, alu_st_in
  );
  modport slave (
    input  start, a_in, b_in, alu_r, alu_st_out,
    output busy, done, p, alu_a, alu_b, alu_op, alu_st_in
  );
endinterface

// File: rtl/alu_mul_ctrl.sv
// alu_mul_ctrl: shift-and-add 8x8->16 multiplier sequencing the shared ALU; ports clk, reset, bus (slave)
module alu_mul_ctrl
  import alu_mul_ctrl_pkg::*;
(
  input logic           clk,
  input logic           reset,
  alu_mul_ctrl_if.slave bus
);
  mul_state_t state;
  mul_state_t nxt;
  logic [7:0] hi;
  logic [7:0] lo;
  logic [7:0] m;
  logic       c;
  logic [2:0] cnt;
  logic       ror;
  always_comb begin
    ror = state == MUL_RORH || state == MUL_RORL;
    nxt = state == MUL_IDLE ? (bus.start ? (bus.b_in[0] ? MUL_ADD : MUL_RORH) : MUL_IDLE) :
          state == MUL_ADD  ? MUL_RORH :
          state == MUL_RORH ? MUL_RORL :
          state == MUL_RORL ? (cnt == 3'd7 ? MUL_FIN : (bus.alu_r[0] ? MUL_ADD : MUL_RORH)) :
          MUL_IDLE;
    bus.alu_op = state == MUL_ADD ? ALU_ADD : ror ? ALU_ROR : ALU_TRA;
    bus.alu_a = (state == MUL_ADD || state == MUL_RORH) ? hi : state == MUL_RORL ? lo : 8'h00;
    bus.alu_b = state == MUL_ADD ? m : 8'h00;
    bus.alu_st_in = ror ? 8'(c) << CF : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MUL_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.p    <= 16'h0000;
      hi       <= 8'h00;
      lo       <= 8'h00;
      m        <= 8'h00;
      c        <= 1'b0;
      cnt      <= 3'd0;
    end else begin
      state    <= nxt;
      bus.busy <= nxt != MUL_IDLE;
      bus.done <= nxt == MUL_FIN;
      case (state)
        MUL_IDLE: if (bus.start) begin
          m   <= bus.a_in;
          lo  <= bus.b_in;
          hi  <= 8'h00;
          c   <= 1'b0;
          cnt <= 3'd0;
        end
        MUL_ADD, MUL_RORH: begin
          hi <= bus.alu_r;
          c  <= bus.alu_st_out[CF];
        end
        MUL_RORL: begin
          lo <= bus.alu_r;
          if (cnt == 3'd7) bus.p <= {hi, bus.alu_r};
          else begin
            c   <= 1'b0;
            cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_ctrl.sv
// tb_alu_mul_ctrl: self-checking bench for alu_mul_ctrl against a behavioural ALU and shift-and-add model
module tb_alu_mul_ctrl;
  import alu_mul_ctrl_pkg::*;
  logic clk;
  logic reset;
  logic co;
  int   vecs;
  int   errs;
  int   cyc;
  int   last_done;
  alu_mul_ctrl_if bus ();
  alu_mul_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always_comb begin
    {co, bus.alu_r} = bus.alu_op == ALU_ADD ? {1'b0, bus.alu_a} + {1'b0, bus.alu_b} :
                      bus.alu_op == ALU_ROR ? {bus.alu_a[0], bus.alu_st_in[CF], bus.alu_a[7:1]} :
                      {1'b0, bus.alu_a};
    bus.alu_st_out = 8'(co) << CF;
  end
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [7:0] a, input logic [7:0] b, input bit hold, input int poke);
    logic [16:0] acc;
    logic [3:0]  qop[$];
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic        qc[$];
    logic [15:0] pexp;
    logic [15:0] pold;
    int          n;
    pexp = 16'(a) * 16'(b);
    pold = bus.p;
    acc = {9'd0, b};
    for (int i = 0; i < 8; i++) begin
      if (acc[0]) begin
        qop.push_back(ALU_ADD); qa.push_back(acc[15:8]); qb.push_back(a); qc.push_back(1'b0);
        acc = acc + {1'b0, a, 8'h00};
      end
      qop.push_back(ALU_ROR); qa.push_back(acc[15:8]); qb.push_back(8'h00); qc.push_back(acc[16]);
      qop.push_back(ALU_ROR); qa.push_back(acc[7:0]);  qb.push_back(8'h00); qc.push_back(acc[8]);
      acc = acc >> 1;
    end
    n = qop.size();
    bus.start = 1'b1;
    bus.a_in = a;
    bus.b_in = b;
    for (int e = 1; e <= n + 2; e++) begin
      @(negedge clk);
      chk($sformatf("busy@%0d", e), bus.busy, e <= n + 1);
      chk($sformatf("done@%0d", e), bus.done, e == n + 1);
      if (e <= n) begin
        chk($sformatf("op@%0d", e), bus.alu_op, qop[e-1]);
        chk($sformatf("alu_a@%0d", e), bus.alu_a, qa[e-1]);
        chk($sformatf("alu_b@%0d", e), bus.alu_b, qb[e-1]);
        chk($sformatf("st_in@%0d", e), bus.alu_st_in, 8'(qc[e-1]) << CF);
        chk($sformatf("p_hold@%0d", e), bus.p, pold);
      end else begin
        chk($sformatf("op_idle@%0d", e), bus.alu_op, ALU_TRA);
        chk($sformatf("st_idle@%0d", e), bus.alu_st_in, 8'h00);
        chk($sformatf("ab_idle@%0d", e), {bus.alu_a, bus.alu_b}, 16'h0000);
        chk($sformatf("p@%0d", e), bus.p, pexp);
      end
      if (e == n + 1 && bus.done) begin
        if (hold && last_done > 0) chk("done_period", cyc - last_done, n + 2);
        last_done = cyc;
      end
      if (!hold) begin
        bus.start = e == poke;
        bus.a_in = e == poke ? 8'hFF : 8'($urandom);
        bus.b_in = e == poke ? 8'hFF : 8'($urandom);
      end
    end
  endtask
  initial begin
    vecs = 0;
    errs = 0;
    cyc = 0;
    last_done = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a_in = 8'h00;
    bus.b_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_p", bus.p, 16'h0000);
    chk("rst_op", bus.alu_op, ALU_TRA);
    reset = 1'b0;
    run(8'h0D, 8'h0B, 1'b0, 0);
    chk("p_0d_0b", bus.p, 16'h008F);
    run(8'hFF, 8'hFF, 1'b0, 0);
    chk("p_ff_ff", bus.p, 16'hFE01);
    run(8'h80, 8'h02, 1'b0, 0);
    chk("p_80_02", bus.p, 16'h0100);
    run(8'h37, 8'h00, 1'b0, 0);
    chk("p_37_00", bus.p, 16'h0000);
    run(8'h12, 8'h34, 1'b0, 5);
    chk("p_12_34", bus.p, 16'h03A8);
    bus.start = 1'b1;
    bus.a_in = 8'hFF;
    bus.b_in = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_before_rst", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_p", bus.p, 16'h0000);
    chk("midrst_op", bus.alu_op, ALU_TRA);
    run(8'h02, 8'h03, 1'b0, 0);
    chk("p_02_03", bus.p, 16'h0006);
    for (int i = 0; i < 6; i++) run(8'($urandom), 8'($urandom), 1'b0, 0);
    last_done = 0;
    for (int i = 0; i < 3; i++) begin
      run(8'h03, 8'h05, 1'b1, 0);
      chk("p_03_05", bus.p, 16'h000F);
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", bus.busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alu_mul_ctrl.md
Name: alu_mul_ctrl

Overview:
- Multi-cycle controller that sequences the shared 8-bit ALU to compute an unsigned 8x8 -> 16-bit product by shift-and-add.
- It issues only `ALU_ADD` and `ALU_ROR` operations and chains the carry flag between steps.
- It sits beside the ALU in the YASAC datapath and drives the ALU inputs through a mux owned by the CPU control unit while busy is high.
- The ALU is purely combinational. The controller registers the ALU result and flags at each clock edge.

Parameters:
- None. Width is fixed at 8 by the ALU, and the iteration count is fixed at 8.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- a_in  in  8  multiplicand, captured when start is accepted
- b_in  in  8  multiplier, captured when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  high for exactly one cycle, in state FIN
- p  out  16  product register; valid while done is high, held until the next completion
- alu_a  out  8  ALU operand a
- alu_b  out  8  ALU operand b
- alu_op  out  4  ALU operation selector, using the codes from globals.vh
- alu_st_in  out  8  ALU status input
- alu_r  in  8  ALU result
- alu_st_out  in  8  ALU status output; only bit `CF is used

Behaviour:
- Internal registers:
  - hi[7:0], lo[7:0]: partial product
  - m[7:0]: multiplicand
  - c: carry bit
  - cnt[2:0]: iteration counter
  - state
- Reset (synchronous, and it wins over everything, including mid-operation):
  - state=IDLE
  - busy=0, done=0, p=16'h0000
  - hi=lo=m=0, c=0, cnt=0
- States: IDLE, ADD, RORH, RORL, FIN.
- ALU drive values are combinational from state; every bit not listed below is 0:
  - IDLE/FIN: alu_op=`ALU_TRA, alu_a=0, alu_b=0, alu_st_in=0.
  - ADD: alu_op=`ALU_ADD, alu_a=hi, alu_b=m, alu_st_in=0.
  - RORH: alu_op=`ALU_ROR, alu_a=hi, alu_b=0, alu_st_in[`CF]=c.
  - RORL: alu_op=`ALU_ROR, alu_a=lo, alu_b=0, alu_st_in[`CF]=c.
- Transitions:
  - IDLE & start: m<=a_in, lo<=b_in, hi<=0, c<=0, cnt<=0; next = b_in[0] ? ADD : RORH.
  - IDLE & !start: stay in IDLE.
  - ADD: hi<=alu_r, c<=alu_st_out[`CF]; next = RORH.
  - RORH: hi<=alu_r, c<=alu_st_out[`CF] (the old hi[0]); next = RORL.
  - RORL when cnt!=7: lo<=alu_r, c<=0, cnt<=cnt+1; next = alu_r[0] ? ADD : RORH.
  - RORL when cnt==7: lo<=alu_r, p<={hi, alu_r}; next = FIN.
  - FIN: done=1; next = IDLE unconditionally.
- Arithmetic:
  - Each iteration right-shifts {c, hi, lo} by one.
  - The ADD step is skipped when lo[0]=0, and c is then 0.
  - After 8 iterations, {hi, lo} = a_in * b_in, an exact 16-bit unsigned product.
  - The carry out of ADD is never lost, because it is shifted into hi[7].
- Latency:
  - Let the accepting edge be edge 0.
  - The ALU-op states occupy cycles 1..N, where N = 16 + popcount(b_in).
  - FIN, with done=1, occurs in cycle N+1.
  - Minimum is 17 cycles (b_in=0x00); maximum is 25 cycles (b_in=0xFF).
- Boundary conditions:
  - start while busy: ignored, with no effect on operands or state.
  - start held high across FIN: the request is accepted on the first IDLE cycle after FIN. Back-to-back throughput is therefore N+2 cycles.
  - a_in/b_in changes after acceptance: no effect.
  - p is updated only on the RORL->FIN transition. It holds its value through IDLE and during a subsequent multiply.
  - Reset mid-operation: the result is discarded and p is cleared to 0.

Decomposition:
- globals.vh (shared):
  - Existing ALU op codes `ALU_ADD, `ALU_ROR, `ALU_TRA and flag index `CF are used unchanged.
  - Add `MUL_IDLE, `MUL_ADD, `MUL_RORH, `MUL_RORL, `MUL_FIN state codes (3 bits).
- No sub-module. The ALU is instantiated by the enclosing datapath, not inside this block. The bench instantiates alu and alu_mul_ctrl side by side.

Test Plan:
- reset, then a_in=0x0D, b_in=0x0B, pulse start -> busy=1 from cycle 1; done=1 in cycle 20 only; p=0x008F; busy=0 in cycle 21.
- a_in=0xFF, b_in=0xFF -> done in cycle 25, p=0xFE01. This exercises the ADD carry into hi[7] on every iteration.
- a_in=0x80, b_in=0x02 -> p=0x0100 at cycle 18; a_in=0x37, b_in=0x00 -> p=0x0000 at cycle 17, with no ADD state visited (alu_op never `ALU_ADD).
- During a multiply of 0x12*0x34, assert start with a_in=b_in=0xFF at cycle 5 -> ignored; p=0x03A8.
- Start 0xFF*0xFF, assert reset at cycle 10 -> next cycle state=IDLE, busy=0, done=0, p=0x0000; a following 0x02*0x03 gives p=0x0006.
- Hold start high continuously with a_in=0x03, b_in=0x05 -> done pulses every 20 cycles (N=18, plus FIN and IDLE), p=0x000F each time; check the alu_st_in[`CF] sequence against a reference model.
